// File: rtl/ringbuffer_counted_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : ringbuffer_counted_pkg                                        |
// | Purpose  : Shared constants for the counted capture ring buffer: default |
// |            geometry, depth helper, lost-entry counter width and the      |
// |            full-ring policy encodings.                                   |
// | Ports    : none (package)                                                |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
package ringbuffer_counted_pkg;

  localparam int DEFAULT_AW = 8;
  localparam int DEFAULT_DW = 48;

  // Width of the lost-entry counter; it saturates at its all-ones value.
  localparam int DROP_CNT_W = 16;

  // Full-ring policy encodings for the OVERWRITE parameter.
  localparam int MODE_DROP      = 0;
  localparam int MODE_OVERWRITE = 1;

  // Ring depth for a given address width; every slot is usable.
  function automatic int depth_of(input int aw);
    return 1 << aw;
  endfunction

  localparam int DEFAULT_DEPTH = depth_of(DEFAULT_AW);

endpackage
`default_nettype wire

// File: rtl/ringbuffer_counted_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : ringbuffer_counted_if                                         |
// | Purpose  : Bundles the write, read, status and loss-accounting signals   |
// |            of the counted ring buffer.                                   |
// | Ports    : master - producer/consumer side (drives enables, data, clear) |
// |            slave  - ring buffer side (drives read data and status)       |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
interface ringbuffer_counted_if
  import ringbuffer_counted_pkg::*;
#(
  parameter int AW = DEFAULT_AW,
  parameter int DW = DEFAULT_DW
);

  logic                  write_clock_enable;
  logic [DW-1:0]         write_data;
  logic                  read_clock_enable;
  logic [DW-1:0]         read_data;
  logic                  read_valid;
  logic                  empty;
  logic                  full;
  logic                  almost_full;
  logic [AW:0]           level;
  logic                  overflow;
  logic [DROP_CNT_W-1:0] drop_count;
  logic                  clear_overflow;

  modport master (
    output write_clock_enable, write_data, read_clock_enable, clear_overflow,
    input  read_data, read_valid, empty, full, almost_full, level,
           overflow, drop_count
  );

  modport slave (
    input  write_clock_enable, write_data, read_clock_enable, clear_overflow,
    output read_data, read_valid, empty, full, almost_full, level,
           overflow, drop_count
  );

endinterface
`default_nettype wire

// File: rtl/ringbuffer_counted_mem.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : ringbuffer_counted_mem                                        |
// | Purpose  : Simple dual-port RAM, 2^AW x DW, synchronous registered read. |
// | Ports    : clock, reset      - clock and sync reset of the output reg    |
// |            write_enable/addr/data - write port                           |
// |            read_enable/addr  - read port, result in read_data next cycle |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module ringbuffer_counted_mem
  import ringbuffer_counted_pkg::*;
#(
  parameter int AW = DEFAULT_AW,
  parameter int DW = DEFAULT_DW
) (
  input  wire           clock,
  input  wire           reset,
  input  wire           write_enable,
  input  wire [AW-1:0]  write_addr,
  input  wire [DW-1:0]  write_data,
  input  wire           read_enable,
  input  wire [AW-1:0]  read_addr,
  output logic [DW-1:0] read_data
);

  localparam int DEPTH = depth_of(AW);

  logic [DW-1:0] mem [DEPTH];

  always_ff @(posedge clock) begin
    if (write_enable) begin
      mem[write_addr] <= write_data;
    end
  end

  // Read-before-write on a shared address: the old word is returned, so a
  // simultaneous read and write on a full ring never sees the new entry.
  always_ff @(posedge clock) begin
    if (reset) begin
      read_data <= '0;
    end else if (read_enable) begin
      read_data <= mem[read_addr];
    end
  end

endmodule
`default_nettype wire

// File: rtl/ringbuffer_counted.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : ringbuffer_counted                                            |
// | Purpose  : Capture ring buffer with fill level, almost-full threshold,   |
// |            drop-new or overwrite-oldest full policy and a saturating     |
// |            lost-entry counter with sticky overflow flag.                 |
// | Ports    : clock, reset - single clock, synchronous active-high reset    |
// |            bus (slave)  - write/read handshake, status, loss accounting  |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module ringbuffer_counted
  import ringbuffer_counted_pkg::*;
#(
  parameter int AW          = DEFAULT_AW,
  parameter int DW          = DEFAULT_DW,
  parameter int OVERWRITE   = MODE_DROP,
  parameter int AFULL_LEVEL = depth_of(AW) - 4
) (
  input wire                  clock,
  input wire                  reset,
  ringbuffer_counted_if.slave bus
);

  localparam int          DEPTH         = depth_of(AW);
  localparam logic [AW:0] C_FULL_LEVEL  = (AW+1)'(DEPTH);
  localparam logic [AW:0] C_AFULL_LEVEL = (AW+1)'(AFULL_LEVEL);
  localparam bit          C_OVERWRITE   = (OVERWRITE == MODE_OVERWRITE);

  logic [AW-1:0]         r_read_addr;
  logic [AW-1:0]         r_write_addr;
  logic [AW:0]           r_level;
  logic                  r_overflow;
  logic [DROP_CNT_W-1:0] r_drop_count;
  logic                  r_read_valid;
  logic [DW-1:0]         w_mem_rdata;

  logic w_empty;
  logic w_full;
  logic w_rd_acc;
  logic w_store_fit;
  logic w_lost;
  logic w_overwrite;
  logic w_mem_we;

  assign w_empty = (r_level == '0);
  assign w_full  = (r_level == C_FULL_LEVEL);

  // A read only proceeds on stored data; a write into an empty ring is never
  // forwarded to the read side in the same cycle.
  assign w_rd_acc    = bus.read_clock_enable && !w_empty;
  // A write fits if there is room, or if the same-edge read frees a slot.
  assign w_store_fit = bus.write_clock_enable && (!w_full || w_rd_acc);
  assign w_lost      = bus.write_clock_enable && w_full && !w_rd_acc;
  // Overwrite mode: the oldest entry is pushed out by advancing the read side.
  assign w_overwrite = C_OVERWRITE && w_lost;
  assign w_mem_we    = w_store_fit || w_overwrite;

  ringbuffer_counted_mem #(
    .AW (AW),
    .DW (DW)
  ) u_mem (
    .clock        (clock),
    .reset        (reset),
    .write_enable (w_mem_we),
    .write_addr   (r_write_addr),
    .write_data   (bus.write_data),
    .read_enable  (w_rd_acc),
    .read_addr    (r_read_addr),
    .read_data    (w_mem_rdata)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      r_read_addr  <= '0;
      r_write_addr <= '0;
      r_level      <= '0;
      r_overflow   <= 1'b0;
      r_drop_count <= '0;
      r_read_valid <= 1'b0;
    end else begin
      r_read_valid <= w_rd_acc;

      if (w_rd_acc || w_overwrite) begin
        r_read_addr <= r_read_addr + 1'b1;
      end
      if (w_mem_we) begin
        r_write_addr <= r_write_addr + 1'b1;
      end

      // An overwrite leaves the level at full, so only fitting writes count.
      if (w_store_fit && !w_rd_acc) begin
        r_level <= r_level + 1'b1;
      end else if (w_rd_acc && !w_store_fit) begin
        r_level <= r_level - 1'b1;
      end

      // A loss in the clearing cycle is recorded as the first new loss.
      if (bus.clear_overflow) begin
        r_overflow   <= w_lost;
        r_drop_count <= w_lost ? DROP_CNT_W'(1) : '0;
      end else if (w_lost) begin
        r_overflow <= 1'b1;
        if (r_drop_count != '1) begin
          r_drop_count <= r_drop_count + 1'b1;
        end
      end
    end
  end

  assign bus.read_data   = w_mem_rdata;
  assign bus.read_valid  = r_read_valid;
  assign bus.empty       = w_empty;
  assign bus.full        = w_full;
  assign bus.almost_full = (r_level >= C_AFULL_LEVEL);
  assign bus.level       = r_level;
  assign bus.overflow    = r_overflow;
  assign bus.drop_count  = r_drop_count;

endmodule
`default_nettype wire

// File: doc/ringbuffer_counted.md
# ringbuffer_counted

Parametrised successor to the capture FIFO between the LPC decoder and the UART/host readout path. Stores DW-bit captured cycles in a 2^AW-entry ring. Every slot is usable, so a full ring holds 2^AW entries. Reports fill level and an almost-full threshold. Handles a full ring in one of two modes: drop the new entry, or overwrite the oldest one. Counts lost entries so the host can detect gaps in the capture stream.

## Interface
Parameters:
- AW, 8, address width; depth = 2^AW entries
- DW, 48, data width
- OVERWRITE, 0, full-ring policy: 0 = drop new write, 1 = discard oldest entry and accept new write
- AFULL_LEVEL, 2^AW-4, almost_full asserts when level >= AFULL_LEVEL

Ports:
- clock  in  1  single clock, all logic on rising edge
- reset  in  1  synchronous, active-high
- write_clock_enable  in  1  write request, one entry per cycle
- write_data  in  DW  entry to store
- read_clock_enable  in  1  read request, one entry per cycle
- read_data  out  DW  registered read result
- read_valid  out  1  read_data holds a new entry this cycle (1-cycle pulse)
- empty  out  1  level == 0
- full  out  1  level == 2^AW
- almost_full  out  1  level >= AFULL_LEVEL
- level  out  AW+1  number of stored entries, 0..2^AW
- overflow  out  1  sticky flag: one or more entries have been lost
- drop_count  out  16  number of lost entries, saturating at 65535
- clear_overflow  in  1  clears overflow and drop_count

## Operation
- State registers:
  - read_addr, write_addr: AW bits, wrap modulo 2^AW
  - level: AW+1 bits
  - overflow, drop_count, read_data, read_valid
- Read is accepted when read_clock_enable && !empty. On acceptance:
  - read_data <= mem[read_addr]
  - read_addr increments
  - read_valid = 1 next cycle
- A read request while empty is ignored: read_valid = 0, read_data holds its value.
- Write when not full: mem[write_addr] <= write_data, write_addr increments.
- Write when full, no accepted read, OVERWRITE=0:
  - write is dropped; memory and pointers unchanged
  - overflow set, drop_count increments
- Write when full, no accepted read, OVERWRITE=1:
  - write is stored; write_addr and read_addr both increment; level stays at 2^AW
  - overflow set, drop_count increments
- Write when full with an accepted read (both modes): both complete, nothing is lost, level unchanged.
- Write when empty with read_clock_enable: the write is stored and the read is ignored. There is no fall-through.
- Level update: +1 on write-only, -1 on read-only, unchanged on both or neither. In overwrite-full, level is unchanged.
- clear_overflow zeroes overflow and drop_count. A drop in the same cycle wins: overflow = 1, drop_count = 1.
- drop_count saturates at 65535. overflow stays set.

## Timing
- Reset values:
  - read_addr = write_addr = level = 0
  - empty = 1, full = almost_full = 0
  - overflow = 0, drop_count = 0
  - read_valid = 0, read_data = 0
- Memory contents are not reset.
- Read latency is 1 cycle: request at edge N, read_data and read_valid valid after edge N+1.
- empty, full and almost_full are decoded combinationally from the level register. They reflect the state after the previous edge.
- Sustained throughput: one write plus one read per cycle.
- A reset asserted mid-stream discards all contents at that edge. A pending read produces no read_valid.
- In overwrite mode, a write and a read at the same edge on a full ring never return the slot being written.

## Structure
- Shared package holds:
  - the depth constant derived from AW
  - the drop_count width (16)
  - OVERWRITE mode encodings (MODE_DROP = 0, MODE_OVERWRITE = 1)
- One sub-module: ringbuffer_counted_mem. It is a simple dual-port RAM, 2^AW x DW, with a synchronous registered read, write enable and read enable, and maps to block RAM.
- Pointer, level and flag logic stay in the top module.

## Test plan
- Reset, then write 5 entries (0x1..0x5), then read 5 -> read_data = 0x1..0x5, one read_valid pulse each one cycle after its request; level 5 -> 0; empty = 1.
- AW=3, OVERWRITE=0: write 10 entries 0..9 -> full = 1, level = 8, overflow = 1, drop_count = 2; reading 8 returns 0..7.
- AW=3, OVERWRITE=1: write 10 entries 0..9 -> level = 8, drop_count = 2; reading 8 returns 2..9.
- Full ring with simultaneous write and read for 20 cycles -> level stays 8, drop_count stays 0, data order preserved.
- clear_overflow in the same cycle as a dropped write -> overflow = 1, drop_count = 1. Read on empty with simultaneous write -> read_valid = 0, level = 1.
- Assert reset mid-stream with level = 6 and a read pending -> next cycle level = 0, empty = 1, read_valid = 0, overflow = 0.
